// File: rtl/scene_seq_pkg.sv
// Shared types and defaults for the scene sequencer: FSM states, default sizing
// and the frame counter width.
package scene_seq_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int DEF_NUM_FIELDS = 3;
    localparam int DEF_DATA_W     = 14;
    localparam int DEF_NUM_STAGES = 3;
    localparam int DEF_TIMEOUT_W  = 20;
    localparam int FRAME_CNT_W    = 16;

    // Index width that stays legal when a count collapses to one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Field loading, stage handshake and frame status bundle between the sequencer
// (slave) and its environment (master).
interface scene_sequencer_if #(
    parameter int NUM_FIELDS = scene_seq_pkg::DEF_NUM_FIELDS,
    parameter int DATA_W     = scene_seq_pkg::DEF_DATA_W,
    parameter int NUM_STAGES = scene_seq_pkg::DEF_NUM_STAGES
) ();
    import scene_seq_pkg::*;

    logic [NUM_FIELDS-1:0]          load;
    logic [DATA_W-1:0]              data;
    logic                           continuous;
    logic [NUM_STAGES-1:0]          stage_done;
    logic [NUM_FIELDS*DATA_W-1:0]   fields;
    logic [NUM_STAGES-1:0]          stage_start;
    logic [idx_w(NUM_STAGES)-1:0]   grid_sel;
    logic                           busy;
    logic                           frame_done;
    logic [FRAME_CNT_W-1:0]         frame_count;
    logic                           error;

    modport master (
        output load, data, continuous, stage_done,
        input  fields, stage_start, grid_sel, busy, frame_done, frame_count, error
    );

    modport slave (
        input  load, data, continuous, stage_done,
        output fields, stage_start, grid_sel, busy, frame_done, frame_count, error
    );

endinterface

// File: rtl/scene_sequencer_edge_detect.sv
// Registered rising-edge detector; rise_o is combinational from the live input
// and last cycle's history, and is masked for the first cycle after reset.
module edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] hist_q;
    logic             armed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= sig_i;
            armed_q <= 1'b1;
        end
    end

    // A level held through reset sees zero history; the arm flag stops it reading as an edge.
    assign rise_o = armed_q ? (sig_i & ~hist_q) : '0;

endmodule

// File: rtl/scene_sequencer.sv
// Captures operand fields, then starts each sub-block in turn and waits for its done,
// optionally looping the tail stages; a per-stage watchdog traps into a sticky error.
module scene_sequencer
    import scene_seq_pkg::*;
#(
    parameter int NUM_FIELDS = DEF_NUM_FIELDS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int LOOP_STAGE = NUM_STAGES - 1,
    parameter int TIMEOUT_W  = DEF_TIMEOUT_W
) (
    input  logic             clock,
    input  logic             reset,
    scene_sequencer_if.slave bus
);

    localparam int FIDX_W = idx_w(NUM_FIELDS);
    localparam int SEL_W  = idx_w(NUM_STAGES);

    state_t                       state_q, state_d;
    logic [FIDX_W-1:0]            f_q, f_d;
    logic [SEL_W-1:0]             s_q, s_d;
    logic [NUM_FIELDS*DATA_W-1:0] fields_q, fields_d;
    logic [FRAME_CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [TIMEOUT_W-1:0]         wdog_q, wdog_d;

    logic [NUM_FIELDS-1:0]        load_rise;
    logic [NUM_STAGES-1:0]        stage_start;
    logic [SEL_W-1:0]             grid_sel;
    logic                         busy;
    logic                         frame_done;
    logic                         error;

    edge_detect #(.WIDTH(NUM_FIELDS)) u_load_edge (
        .clock  (clock),
        .reset  (reset),
        .sig_i  (bus.load),
        .rise_o (load_rise)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            f_q         <= '0;
            s_q         <= '0;
            fields_q    <= '0;
            frame_cnt_q <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            s_q         <= s_d;
            fields_q    <= fields_d;
            frame_cnt_q <= frame_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        s_d         = s_q;
        fields_d    = fields_q;
        frame_cnt_d = frame_cnt_q;
        wdog_d      = wdog_q;
        stage_start = '0;
        grid_sel    = '0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        error       = 1'b0;

        // Live operand updates while looping; simultaneous edges all take the same data.
        if (bus.continuous && (state_q != ST_LOAD)) begin
            for (int k = 0; k < NUM_FIELDS; k++) begin
                if (load_rise[k]) begin
                    fields_d[k*DATA_W +: DATA_W] = bus.data;
                end
            end
        end

        case (state_q)
            ST_LOAD: begin
                if (load_rise[f_q]) begin
                    fields_d[f_q*DATA_W +: DATA_W] = bus.data;
                    if (f_q == FIDX_W'(NUM_FIELDS - 1)) begin
                        f_d     = '0;
                        s_d     = '0;
                        state_d = ST_START;
                    end else begin
                        f_d = f_q + FIDX_W'(1);
                    end
                end
            end
            ST_START: begin
                stage_start[s_q] = 1'b1;
                busy             = 1'b1;
                grid_sel         = s_q;
                wdog_d           = '0;
                state_d          = ST_WAIT;
            end
            ST_WAIT: begin
                busy     = 1'b1;
                grid_sel = s_q;
                if (bus.stage_done[s_q]) begin
                    if (s_q == SEL_W'(NUM_STAGES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        s_d     = s_q + SEL_W'(1);
                        state_d = ST_START;
                    end
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                    if (&wdog_d) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                if (bus.continuous) begin
                    s_d     = SEL_W'(LOOP_STAGE);
                    state_d = ST_START;
                end else begin
                    f_d     = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign bus.fields      = fields_q;
    assign bus.stage_start = stage_start;
    assign bus.grid_sel    = grid_sel;
    assign bus.busy        = busy;
    assign bus.frame_done  = frame_done;
    assign bus.frame_count = frame_cnt_q;
    assign bus.error       = error;

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer: a frame-level model is compared every cycle,
// plus literal checks on loading, stage order, looping, wrap, reset and watchdog.
module tb_scene_sequencer;

    localparam int NF = 3;
    localparam int DW = 14;
    localparam int NS = 3;
    localparam int WD_TOP = (1 << 20) - 1;
    localparam int PH_LOAD = 0, PH_START = 1, PH_WAIT = 2, PH_DONE = 3, PH_ERR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst2;

    scene_sequencer_if #(.NUM_FIELDS(NF), .DATA_W(DW), .NUM_STAGES(NS)) bus ();
    scene_sequencer_if #(.NUM_FIELDS(NF), .DATA_W(DW), .NUM_STAGES(NS)) bus2 ();

    scene_sequencer #(.NUM_FIELDS(NF), .DATA_W(DW), .NUM_STAGES(NS),
                      .LOOP_STAGE(2), .TIMEOUT_W(20)) dut (
        .clock (clk), .reset (rst), .bus (bus));

    scene_sequencer #(.NUM_FIELDS(NF), .DATA_W(DW), .NUM_STAGES(NS),
                      .LOOP_STAGE(2), .TIMEOUT_W(4)) dut2 (
        .clock (clk), .reset (rst2), .bus (bus2));

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;
    bit force_on = 0;

    // Frame-level model of the main instance
    int m_ph, m_f, m_s, m_wd, m_frames;
    logic [DW-1:0] m_fld [NF];
    logic [NF-1:0] m_prev;
    bit m_armed;

    logic [NS-1:0] starts[$];
    int fd_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_tick();
        logic [NF-1:0] rise;
        int ph;
        if (rst) begin
            m_ph = PH_LOAD; m_f = 0; m_s = 0; m_wd = 0; m_frames = 0;
            m_prev = '0; m_armed = 0;
            for (int i = 0; i < NF; i++) m_fld[i] = '0;
        end else begin
            rise = m_armed ? (bus.load & ~m_prev) : '0;
            m_prev = bus.load;
            m_armed = 1;
            ph = m_ph;
            if (bus.continuous && ph != PH_LOAD)
                for (int k = 0; k < NF; k++) if (rise[k]) m_fld[k] = bus.data;
            case (ph)
                PH_LOAD: if (rise[m_f]) begin
                    m_fld[m_f] = bus.data;
                    if (m_f == NF - 1) begin m_f = 0; m_s = 0; m_ph = PH_START; end
                    else m_f++;
                end
                PH_START: begin m_wd = 0; m_ph = PH_WAIT; end
                PH_WAIT: begin
                    if (bus.stage_done[m_s]) begin
                        if (m_s == NS - 1) m_ph = PH_DONE;
                        else begin m_s++; m_ph = PH_START; end
                    end else if (m_wd + 1 == WD_TOP) m_ph = PH_ERR;
                    else m_wd++;
                end
                PH_DONE: begin
                    m_frames = (m_frames + 1) % 65536;
                    if (bus.continuous) begin m_s = 2; m_ph = PH_START; end
                    else begin m_f = 0; m_ph = PH_LOAD; end
                end
                default: ;
            endcase
        end
        if (force_on) m_frames = 16'hFFFF;
    endtask

    task automatic compare();
        logic [NS-1:0] es;
        logic [NF*DW-1:0] ef;
        bit act;
        es = '0;
        if (m_ph == PH_START) es[m_s] = 1'b1;
        for (int i = 0; i < NF; i++) ef[i*DW +: DW] = m_fld[i];
        act = (m_ph == PH_START || m_ph == PH_WAIT);
        chk("stage_start", bus.stage_start, es);
        chk("busy", bus.busy, act);
        chk("grid_sel", bus.grid_sel, act ? m_s : 0);
        chk("frame_done", bus.frame_done, m_ph == PH_DONE);
        chk("error", bus.error, m_ph == PH_ERR);
        chk("frame_count", bus.frame_count, force_on ? 64'hFFFF : m_frames);
        chk("fields", bus.fields, ef);
        if (bus.stage_start != '0) starts.push_back(bus.stage_start);
        if (bus.frame_done) fd_cnt++;
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            if (chk_en) compare();
            @(posedge clk);
            model_tick();
            #1;
        end
    endtask

    task automatic load_field(input int idx, input logic [DW-1:0] val);
        bus.data = val;
        bus.load = '0;
        bus.load[idx] = 1'b1;
        step();
        bus.load = '0;
    endtask

    task automatic wait_start(input int idx);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.stage_start[idx]) found = 1;
            else step();
        end
        chk($sformatf("start_%0d_seen", idx), found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [NF*DW-1:0] exp_f;
        logic [NS-1:0] pend, acc;
        bit ok, found;
        int fc0;

        rst = 1; rst2 = 1;
        bus.load = 3'b001; bus.data = '0; bus.continuous = 0; bus.stage_done = '0;
        bus2.load = '0; bus2.data = '0; bus2.continuous = 0; bus2.stage_done = '0;
        step(3);
        chk_en = 1;
        chk("rst_stage_start", bus.stage_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fields", bus.fields, 0);
        chk("rst_frame_count", bus.frame_count, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_grid_sel", bus.grid_sel, 0);

        // load[0] held through reset is not an edge
        rst = 0;
        step(3);
        chk("held_through_reset", bus.fields[13:0], 0);
        bus.load = '0;
        step();

        // wrong-index edge ignored, held bit captured once
        bus.data = 14'h0077; bus.load = 3'b010; step(); bus.load = '0; step();
        chk("wrong_index_ignored", bus.fields[27:14], 0);
        bus.data = 14'h0005; bus.load = 3'b001; step();
        bus.data = 14'h0099; step(9);
        bus.load = '0; step();
        chk("held_capture_once", bus.fields[13:0], 14'h0005);
        chk("field1_unchanged", bus.fields[27:14], 0);

        load_field(1, 14'h0003);
        load_field(2, 14'h00C8);
        exp_f = {14'h00C8, 14'h0003, 14'h0005};
        chk("fields_frame1", bus.fields, exp_f);
        starts.delete(); fd_cnt = 0;

        wait_start(0);
        bus.stage_done = 3'b001; step();
        bus.stage_done = 3'b100; step(2);
        bus.stage_done = 3'b001; step();
        chk("start_1", bus.stage_start, 3'b010);
        bus.stage_done = 3'b010; step(2);
        chk("gap_two_cycles", bus.stage_start, 3'b100);
        bus.stage_done = '0; step(2);
        bus.stage_done = 3'b100; step();
        chk("frame_done_pulse", bus.frame_done, 1);
        bus.stage_done = '0; step();
        chk("frame_count_1", bus.frame_count, 1);
        chk("idle_after_frame", bus.busy, 0);
        ok = (starts.size() == 3) && (starts[0] == 3'b001) && (starts[1] == 3'b010) && (starts[2] == 3'b100);
        chk("start_order", ok, 1);
        chk("frame_done_once", fd_cnt, 1);

        // continuous looping with live field updates
        bus.continuous = 1;
        load_field(0, 14'h0010);
        load_field(1, 14'h0020);
        load_field(2, 14'h0030);
        starts.delete(); fd_cnt = 0;
        fc0 = int'(bus.frame_count);
        pend = bus.stage_start;
        for (int i = 0; i < 30; i++) begin
            step();
            bus.stage_done = pend;
            pend = bus.stage_start;
            if (i == 10) begin bus.data = 14'h01AB; bus.load = 3'b010; end
            if (i == 11) bus.load = '0;
            if (i == 14) begin bus.data = 14'h02CD; bus.load = 3'b101; end
            if (i == 15) bus.load = '0;
        end
        bus.stage_done = '0;
        step(4);
        ok = (starts.size() >= 6) && (starts[0] == 3'b001) && (starts[1] == 3'b010);
        for (int i = 2; i < starts.size(); i++) if (starts[i] != 3'b100) ok = 0;
        chk("loop_only_last_stage", ok, 1);
        chk("loop_frame_count", int'(bus.frame_count) - fc0, fd_cnt);
        chk("loop_frames_ran", fd_cnt >= 3, 1);
        exp_f = {14'h02CD, 14'h01AB, 14'h02CD};
        chk("live_field_update", bus.fields, exp_f);
        chk("parked_wait_busy", bus.busy, 1);
        chk("parked_wait_sel", bus.grid_sel, 2);

        // frame counter wrap
        bus.continuous = 0;
        force dut.frame_cnt_q = 16'hFFFF;
        force_on = 1;
        step();
        release dut.frame_cnt_q;
        force_on = 0;
        chk("preload_held", bus.frame_count, 16'hFFFF);
        bus.stage_done = 3'b100; step();
        chk("wrap_frame_done", bus.frame_done, 1);
        bus.stage_done = '0; step();
        chk("wrap_to_zero", bus.frame_count, 0);

        // reset in WAIT of stage 1
        load_field(0, 14'h0001);
        load_field(1, 14'h0002);
        load_field(2, 14'h0003);
        wait_start(0);
        bus.stage_done = 3'b001; step(2);
        wait_start(1);
        bus.stage_done = '0; step();
        chk("mid_wait_busy", bus.busy, 1);
        chk("mid_wait_sel", bus.grid_sel, 1);
        rst = 1; step(); rst = 0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_start", bus.stage_start, 0);
        chk("midrst_fields", bus.fields, 0);
        chk("midrst_sel", bus.grid_sel, 0);
        bus.stage_done = 3'b010; step();
        bus.stage_done = '0; step(2);
        chk("late_done_no_start", bus.stage_start, 0);
        chk("late_done_idle", bus.busy, 0);

        // watchdog on the short-timeout instance
        rst2 = 0; step(2);
        for (int k = 0; k < NF; k++) begin
            bus2.data = DW'(k + 1);
            bus2.load = '0; bus2.load[k] = 1'b1; step();
            bus2.load = '0; step();
        end
        bus2.stage_done = 3'b001;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus2.stage_start[1]) found = 1;
            else step();
        end
        chk("wd_start_1_seen", found, 1);
        bus2.stage_done = '0;
        step(15);
        chk("wd_not_yet", bus2.error, 0);
        step();
        chk("wd_error_at_15", bus2.error, 1);
        chk("wd_error_busy", bus2.busy, 0);
        acc = '0;
        bus2.stage_done = 3'b010;
        for (int i = 0; i < 10; i++) begin
            step();
            bus2.stage_done = '0;
            acc |= bus2.stage_start;
        end
        chk("wd_no_starts", acc, 0);
        chk("wd_sticky", bus2.error, 1);
        rst2 = 1; step(); rst2 = 0;
        chk("wd_cleared_by_reset", bus2.error, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
